// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer: walks the valid-conv loop nest (oci, j, i, ico, wj, wi)
// and emits one counter tuple per beat over a valid/ready handshake, with
// first/last accumulation markers for the popcount pipeline.
// Optional: define CONV_SEQ_BEAT_COUNT_EN to add beat_cnt_o, a count of
// transferred beats.
module conv_loop_sequencer #(
  parameter int unsigned KS = 3,
  parameter int unsigned CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [CW-1:0] iw_i,
  input  logic [CW-1:0] ih_i,
  input  logic [CW-1:0] ic_i,
  input  logic [CW-1:0] oc_i,
  output logic [CW-1:0] oci_o,
  output logic [CW-1:0] j_o,
  output logic [CW-1:0] i_o,
  output logic [CW-1:0] ico_o,
  output logic [CW-1:0] wj_o,
  output logic [CW-1:0] wi_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          first_o,
  output logic          last_o,
  output logic          busy_o,
  output logic          done_o
`ifdef CONV_SEQ_BEAT_COUNT_EN
  ,
  output logic [CW-1:0] beat_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] KS_W = CW'(KS);
  localparam logic [CW-1:0] KM1  = CW'(KS - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] ow, oh, icw, ocl;
  logic [CW-1:0] oci, j, i, ico, wj, wi;
  logic          shape_ok, launch, xfer;
  logic          c_wj, c_ico, c_i, c_j, c_oci, final_beat;

  // Shape legality is judged on the live inputs at the start pulse.
  assign shape_ok = (iw_i >= KS_W) && (ih_i >= KS_W) &&
                    ((ic_i >> 5) != '0) && (oc_i != '0);
  assign launch   = (state == IDLE) && start_i;
  assign xfer     = valid_o && ready_i;

  // Carry chain: each counter advances when every inner counter wraps.
  assign c_wj       = (wi == KM1);
  assign c_ico      = c_wj  && (wj == KM1);
  assign c_i        = c_ico && (ico == icw - 1'b1);
  assign c_j        = c_i   && (i == ow - 1'b1);
  assign c_oci      = c_j   && (j == oh - 1'b1);
  assign final_beat = c_oci && (oci == ocl - 1'b1);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is dropped, not queued
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = shape_ok ? RUN : DONE;
      RUN:     if (xfer && final_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shape latch: captured once per start so the CSRs may change mid-layer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ow <= '0; oh <= '0; icw <= '0; ocl <= '0;
    end else if (launch) begin
      ow  <= iw_i - KS_W + 1'b1;
      oh  <= ih_i - KS_W + 1'b1;
      icw <= ic_i >> 5;
      ocl <= oc_i;
    end
  end

  // Loop counters: advance only on a transfer, so a stall holds the tuple
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oci <= '0; j <= '0; i <= '0; ico <= '0; wj <= '0; wi <= '0;
    end else if (launch || (xfer && final_beat)) begin
      oci <= '0; j <= '0; i <= '0; ico <= '0; wj <= '0; wi <= '0;
    end else if (xfer) begin
      wi <= c_wj ? '0 : wi + 1'b1;
      if (c_wj)  wj  <= c_ico ? '0 : wj + 1'b1;
      if (c_ico) ico <= c_i   ? '0 : ico + 1'b1;
      if (c_i)   i   <= c_j   ? '0 : i + 1'b1;
      if (c_j)   j   <= c_oci ? '0 : j + 1'b1;
      if (c_oci) oci <= oci + 1'b1;
    end
  end

`ifdef CONV_SEQ_BEAT_COUNT_EN
  // Transferred-beat count; holds after done until the next start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     beat_cnt_o <= '0;
    else if (launch) beat_cnt_o <= '0;
    else if (xfer)   beat_cnt_o <= beat_cnt_o + 1'b1;
  end
`endif

  assign valid_o = (state == RUN);
  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);
  assign first_o = valid_o && (ico == '0) && (wj == '0) && (wi == '0);
  assign last_o  = valid_o && c_ico && (ico == icw - 1'b1);

  assign oci_o = oci;
  assign j_o   = j;
  assign i_o   = i;
  assign ico_o = ico;
  assign wj_o  = wj;
  assign wi_o  = wi;

endmodule
